// File: rtl/neuron_sum_pkg.sv
// Shared definitions for the neuron summation slice.
// Holds the default operand width, chunk size and chunk limit used by
// neuron_sum_seq and its environment, plus the controller state encoding.
// No ports: this file is a package only.
package neuron_sum_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_COUNT      = 128;
    localparam int DEF_MAX_CHUNKS = 16;

    // IDLE waits for a job, WAIT waits for a chunk, SUM folds one chunk
    // into the accumulator, DONE presents the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SUM  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/neuron_sum_seq.sv
// Sequential controller that accumulates one neuron over several operand
// chunks using an external combinational adder tree.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cfg_valid/cfg_ready             job descriptor handshake
//   cfg_num_chunks, cfg_bias,
//   cfg_relu                        chunks in the job, bias, ReLU enable
//   in_valid/in_ready, in_data      operand chunk stream (COUNT operands)
//   tree_a, tree_bias, tree_en      operands, running sum and ReLU enable
//                                   driven into the adder tree
//   tree_c                          reduced result returned by the tree
//   out_valid/out_ready, out_data   neuron result handshake
//   busy                            high whenever a job is in flight
module neuron_sum_seq
    import neuron_sum_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int COUNT      = DEF_COUNT,
    parameter int MAX_CHUNKS = DEF_MAX_CHUNKS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [$clog2(MAX_CHUNKS):0]       cfg_num_chunks,
    input  logic [DATA_WIDTH-1:0]             cfg_bias,
    input  logic                              cfg_relu,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [COUNT-1:0][DATA_WIDTH-1:0]  in_data,
    output logic [COUNT-1:0][DATA_WIDTH-1:0]  tree_a,
    output logic [DATA_WIDTH-1:0]             tree_bias,
    output logic                              tree_en,
    input  logic [DATA_WIDTH-1:0]             tree_c,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              busy
);

    localparam int CW = $clog2(MAX_CHUNKS) + 1;

    state_t                           state_q;
    logic [CW-1:0]                    numChunks_q;
    logic [CW-1:0]                    numChunks_d;
    logic [CW-1:0]                    chunkCnt_q;
    logic                             relu_q;
    logic [DATA_WIDTH-1:0]            acc_q;
    logic [COUNT-1:0][DATA_WIDTH-1:0] treeA_q;
    logic [DATA_WIDTH-1:0]            outData_q;
    logic                             outValid_q;
    logic                             cfgReady_q;
    logic                             inReady_q;
    logic                             treeEn_q;
    logic                             busy_q;
    logic                             lastChunk;

    // A zero chunk count still means one chunk; anything above the
    // supported limit is clamped so the counter can never run away.
    always_comb begin
        numChunks_d = cfg_num_chunks;
        if (cfg_num_chunks == '0) begin
            numChunks_d = CW'(1);
        end else if (cfg_num_chunks > CW'(MAX_CHUNKS)) begin
            numChunks_d = CW'(MAX_CHUNKS);
        end
    end

    assign lastChunk = (chunkCnt_q == (numChunks_q - CW'(1)));

    // Controller FSM. Every handshake flag is registered together with the
    // state so the outputs are glitch-free. tree_en is only raised for the
    // final SUM so partial sums pass through the tree unclamped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            numChunks_q <= CW'(1);
            chunkCnt_q  <= '0;
            relu_q      <= 1'b0;
            acc_q       <= '0;
            treeA_q     <= '0;
            outData_q   <= '0;
            outValid_q  <= 1'b0;
            cfgReady_q  <= 1'b1;
            inReady_q   <= 1'b0;
            treeEn_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        numChunks_q <= numChunks_d;
                        relu_q      <= cfg_relu;
                        acc_q       <= cfg_bias;
                        chunkCnt_q  <= '0;
                        cfgReady_q  <= 1'b0;
                        inReady_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (in_valid) begin
                        treeA_q   <= in_data;
                        inReady_q <= 1'b0;
                        treeEn_q  <= relu_q && lastChunk;
                        state_q   <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    acc_q      <= tree_c;
                    chunkCnt_q <= chunkCnt_q + CW'(1);
                    treeEn_q   <= 1'b0;
                    if (lastChunk) begin
                        outData_q  <= tree_c;
                        outValid_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        inReady_q <= 1'b1;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    // Going through IDLE forces a one-cycle gap before a
                    // new descriptor can be taken.
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        cfgReady_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = cfgReady_q;
    assign in_ready  = inReady_q;
    assign tree_a    = treeA_q;
    assign tree_bias = acc_q;
    assign tree_en   = treeEn_q;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_sum_seq.sv
// Self-checking bench for neuron_sum_seq. The bench supplies the external
// adder tree (sum of all operands plus bias, optional ReLU) and runs a table
// of jobs, a DONE-stall sequence and a mid-job reset.
module tb_neuron_sum_seq;
    import neuron_sum_pkg::*;

    localparam int DW   = DEF_DATA_WIDTH;
    localparam int CNT  = DEF_COUNT;
    localparam int MAXC = DEF_MAX_CHUNKS;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int NVEC = 10;

    logic                     clk;
    logic                     rst_n;
    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [CW-1:0]            cfg_num_chunks;
    logic [DW-1:0]            cfg_bias;
    logic                     cfg_relu;
    logic                     in_valid;
    logic                     in_ready;
    logic [CNT-1:0][DW-1:0]   in_data;
    logic [CNT-1:0][DW-1:0]   tree_a;
    logic [DW-1:0]            tree_bias;
    logic                     tree_en;
    logic [DW-1:0]            tree_c;
    logic                     out_valid;
    logic                     out_ready;
    logic [DW-1:0]            out_data;
    logic                     busy;

    typedef struct {
        int                  numChunks;
        logic [DW-1:0]       bias;
        logic                relu;
        logic [3:0][DW-1:0]  vals;
        logic [DW-1:0]       expected;
    } vec_t;

    vec_t          vecs [NVEC];
    logic [DW-1:0] expQ [$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] treeSum;

    neuron_sum_seq #(
        .DATA_WIDTH (DW),
        .COUNT      (CNT),
        .MAX_CHUNKS (MAXC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_num_chunks (cfg_num_chunks),
        .cfg_bias       (cfg_bias),
        .cfg_relu       (cfg_relu),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .tree_a         (tree_a),
        .tree_bias      (tree_bias),
        .tree_en        (tree_en),
        .tree_c         (tree_c),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .busy           (busy)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder tree stand-in: wrapping sum of bias and every operand, with
    // negative results forced to zero only when tree_en is high.
    always_comb begin
        treeSum = tree_bias;
        for (int i = 0; i < CNT; i++) begin
            treeSum = treeSum + tree_a[i];
        end
        tree_c = (tree_en && treeSum[DW-1]) ? '0 : treeSum;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input int n, input logic [DW-1:0] b,
                                   input logic r, input logic [DW-1:0] v0,
                                   input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                                   input logic [DW-1:0] v3, input logic [DW-1:0] e);
        vec_t v;
        v.numChunks = n;
        v.bias      = b;
        v.relu      = r;
        v.vals      = {v3, v2, v1, v0};
        v.expected  = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits (sampling #1 after each edge) for cfg_ready (0), in_ready (1)
    // or out_valid (2), giving up after 100 cycles.
    task automatic waitFor(input int sel, input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if ((sel == 0 && cfg_ready) || (sel == 1 && in_ready) ||
                (sel == 2 && out_valid)) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s: timeout waiting, got 0 expected 1", name);
    endtask

    task automatic driveChunk(input logic [DW-1:0] val);
        in_valid = 1'b1;
        for (int j = 0; j < CNT; j++) begin
            in_data[j] = val;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Runs one job end to end. hold > 0 keeps out_ready low that many
    // cycles in DONE while spurious in_valid/cfg_valid are presented.
    task automatic applyStimulus(input vec_t v, input int hold);
        int            eff;
        bit            ok;
        logic [DW-1:0] exp;
        eff = (v.numChunks == 0) ? 1 : ((v.numChunks > MAXC) ? MAXC : v.numChunks);
        waitFor(0, "cfg_ready_wait", ok);
        if (!ok) return;
        cfg_valid      = 1'b1;
        cfg_num_chunks = CW'(v.numChunks);
        cfg_bias       = v.bias;
        cfg_relu       = v.relu;
        expQ.push_back(v.expected);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        for (int c = 0; c < eff; c++) begin
            waitFor(1, "in_ready_wait", ok);
            if (!ok) return;
            driveChunk(v.vals[(c < 4) ? c : 3]);
            checkOutput("tree_en_sum", {31'd0, tree_en},
                        {31'd0, v.relu && (c == eff - 1)});
            if (c == 0) checkOutput("tree_bias_first", {16'd0, tree_bias}, {16'd0, v.bias});
            if (c == eff - 1) begin
                checkOutput("out_valid_in_sum", {31'd0, out_valid}, 32'd0);
                @(posedge clk);
                #1;
                checkOutput("latency_out_valid", {31'd0, out_valid}, 32'd1);
            end
        end
        waitFor(2, "out_valid_wait", ok);
        if (!ok) return;
        exp = expQ.pop_front();
        checkOutput("out_data", {16'd0, out_data}, {16'd0, exp});
        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'b1;
            cfg_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("stall_out_data", {16'd0, out_data}, {16'd0, exp});
            checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("stall_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("post_out_busy", {31'd0, busy}, 32'd0);
        checkOutput("post_out_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        checkOutput("post_out_valid", {31'd0, out_valid}, 32'd0);
        cfg_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        vecs[0] = mkVec(1,  16'd5,     1'b0, 16'd1,     16'd1,     16'd1, 16'd1, 16'd133);
        vecs[1] = mkVec(3,  16'hFFF6,  1'b1, 16'd1,     16'd2,     16'd3, 16'd3, 16'd758);
        vecs[2] = mkVec(2,  16'd0,     1'b1, 16'hFFFF,  16'hFFFF,  16'd0, 16'd0, 16'd0);
        vecs[3] = mkVec(2,  16'd0,     1'b0, 16'hFFFF,  16'hFFFF,  16'd0, 16'd0, 16'hFF00);
        vecs[4] = mkVec(1,  16'd0,     1'b0, 16'h0100,  16'd0,     16'd0, 16'd0, 16'h8000);
        vecs[5] = mkVec(1,  16'd0,     1'b1, 16'h0100,  16'd0,     16'd0, 16'd0, 16'd0);
        vecs[6] = mkVec(0,  16'd1,     1'b0, 16'd2,     16'd2,     16'd2, 16'd2, 16'd257);
        vecs[7] = mkVec(20, 16'd0,     1'b0, 16'd1,     16'd1,     16'd1, 16'd1, 16'd2048);
        vecs[8] = mkVec(2,  16'd100,   1'b1, 16'hFFFE,  16'd1,     16'd1, 16'd1, 16'd0);
        vecs[9] = mkVec(2,  16'd100,   1'b0, 16'hFFFE,  16'd1,     16'd1, 16'd1, 16'hFFE4);

        rst_n          = 1'b0;
        cfg_valid      = 1'b0;
        cfg_num_chunks = '0;
        cfg_bias       = '0;
        cfg_relu       = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        out_ready      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_tree_en", {31'd0, tree_en}, 32'd0);
        checkOutput("rst_out_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], 0);
        end

        applyStimulus(vecs[0], 5);

        // Reset while the second of four chunks is being summed.
        waitFor(0, "rst_seq_cfg_wait", ok);
        cfg_valid      = 1'b1;
        cfg_num_chunks = CW'(4);
        cfg_bias       = 16'd7;
        cfg_relu       = 1'b0;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            waitFor(1, "rst_seq_in_wait", ok);
            driveChunk(16'd3);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("abort_tree_en", {31'd0, tree_en}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_out_data", {16'd0, out_data}, 32'd0);
        checkOutput("abort_tree_bias", {16'd0, tree_bias}, 32'd0);
        checkOutput("abort_tree_a_zero", {31'd0, (tree_a == '0)}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_output", {31'd0, out_valid}, 32'd0);
        end
        checkOutput("abort_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        applyStimulus(vecs[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
